ppm_symbol_decoder: RTL
=======================

# ppm_symbol_decoder

Front-end stage of the PPM receive path. Samples the raw 1-of-4 pulse-position-modulated input line, detects frame start, demodulates symbols into bytes and detects frame end. Drives the frame-control stage downstream with single-cycle `sof_rcv_out`, `eof_rcv_out` and `onebyte_out` strobes plus the assembled byte on `dout_data`.

## Interface
- `SLOT_CYCLES`, 8: clk cycles per PPM slot; legal values are ≥4.
- `TOL`, 2: ± cycle tolerance on the SOF pulse gap; must be < SLOT_CYCLES/2.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ppm_in` in 1: raw PPM line (asynchronous), pulse = high.
- `dout_data` out 8: last completed byte; holds until the next byte completes.
- `onebyte_out` out 1: 1-cycle strobe; new byte valid on `dout_data`.
- `sof_rcv_out` out 1: 1-cycle strobe; SOF accepted.
- `eof_rcv_out` out 1: 1-cycle strobe; EOF detected.
- `frame_err` out 1: 1-cycle strobe; malformed frame aborted.
- `busy` out 1: high while state ≠ IDLE.

## Operation
- Input conditioning: 2-flop synchronizer followed by a rising-edge detect. `edge` is high for one cycle, 2 cycles after `ppm_in` is first sampled high. Only edges are used; pulse width is ignored.
- States: IDLE, SOF_GAP, DATA.
- IDLE:
  - On `edge`, clear the gap counter to 0 and go to SOF_GAP.
- SOF_GAP: the gap counter increments each cycle.
  - `edge` with counter in [3·S−TOL, 3·S+TOL] (S = SLOT_CYCLES): accept SOF and go to DATA. Window counters and the symbol index are cleared, and slot 0 of the first window begins the next cycle.
  - `edge` outside that range: treated as a new first pulse. Counter is cleared and the state stays SOF_GAP.
  - Counter reaches 3·S+TOL+1 with no edge: go to IDLE. No strobe.
- DATA:
  - Symbol window = 4 slots × S cycles, tracked by `cyc_cnt` (0..S−1) and `slot_cnt` (0..3). No divider.
  - The first `edge` in a window latches symbol value = `slot_cnt`.
  - Bytes are assembled LSB-first: symbol 0 goes to bits [1:0], symbol 1 to [3:2], symbol 2 to [5:4], symbol 3 to [7:6].
  - On the last cycle of a window (slot 3, cyc S−1), one of the following applies:
    - Edge seen and symbol index = 3: the byte is complete. `dout_data` is loaded, `onebyte_out` pulses, the index wraps to 0 and the next window starts.
    - Edge seen and index < 3: the index increments and the next window starts.
    - No edge and index = 0: EOF. `eof_rcv_out` pulses and the state goes to IDLE.
    - No edge and index ≠ 0: `frame_err` pulses, the state goes to IDLE, and the partial byte is discarded.
  - Second `edge` within one window: `frame_err` pulses and the state goes to IDLE immediately. That edge is consumed and does not arm a new SOF.
- An edge on the last cycle of a window belongs to that window.
- Only one strobe can be high in any cycle.

## Timing
- Reset: state IDLE; `dout_data` = 0x00; all strobes, `busy` and the synchronizer flops = 0.
- Strobes are registered and assert the cycle after the deciding event:
  - `sof_rcv_out`: the cycle after the accepting edge.
  - `onebyte_out` and `eof_rcv_out`: the cycle after the window's last cycle.
- `dout_data` updates on the same clk edge that raises `onebyte_out`, so it is stable whenever the strobe is high.
- `busy` is registered alongside the state.
- Reset asserted mid-frame aborts immediately and emits no strobe. After release, the block waits in IDLE for a fresh SOF.
- Counter width = $clog2(3·S+TOL+2). All comparisons are unsigned.

## Structure
- Shared package `ppm_pkg`: state enum (IDLE, SOF_GAP, DATA), `SLOTS_PER_SYMBOL` = 4, `SOF_GAP_SLOTS` = 3, `SYMBOLS_PER_BYTE` = 4.
- One sub-module, `ppm_edge_sync`: 2-flop synchronizer plus rising-edge detect, on the same `clk`/`rst_n`.
- The FSM, window counters, shift register and output registers live in the top module.

## Test plan
All scenarios use S=8 and TOL=2. Data edge times are given relative to the start of slot 0 of the window.
- SOF edges 24 cycles apart, then edges at cycle 2 of slots 0, 1, 3, 2 → one `sof_rcv_out`, then `onebyte_out` with `dout_data` = 0xB4.
- SOF gap 22 and gap 26 → both accepted. Gap 21 → no `sof_rcv_out`, re-arms on the second edge. Gap of 27+ cycles with no edge → IDLE, `busy` drops.
- One full byte 0x1B, then an empty window → `eof_rcv_out` one cycle after the window end, `busy` = 0, `dout_data` stays 0x1B.
- Two edges in one window (slots 0 and 2) → `frame_err` one cycle after the second edge, no `onebyte_out`, IDLE.
- Two symbols, then an empty window → `frame_err`, no `onebyte_out`, `dout_data` unchanged.
- `rst_n` pulsed low mid-byte → all outputs 0 within the reset. A subsequent SOF plus byte 0xFF decodes correctly.

Source files
------------

// File: rtl/ppm_pkg.sv
// Shared state type and frame-geometry constants for the PPM receive path.
package ppm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SOF_GAP = 2'd1,
        DATA    = 2'd2
    } ppm_state_e;

    localparam int SLOTS_PER_SYMBOL = 4;
    localparam int SOF_GAP_SLOTS    = 3;
    localparam int SYMBOLS_PER_BYTE = 4;

endpackage

// File: rtl/ppm_symbol_decoder_if.sv
// Line-side input and frame-control-side outputs of the PPM symbol decoder.
interface ppm_symbol_decoder_if;

    logic       ppm_in;
    logic [7:0] dout_data;
    logic       onebyte_out;
    logic       sof_rcv_out;
    logic       eof_rcv_out;
    logic       frame_err;
    logic       busy;

    // The driver of the PPM line and consumer of the decoded strobes.
    modport master (
        output ppm_in,
        input  dout_data, onebyte_out, sof_rcv_out, eof_rcv_out, frame_err, busy
    );

    // The decoder itself.
    modport slave (
        input  ppm_in,
        output dout_data, onebyte_out, sof_rcv_out, eof_rcv_out, frame_err, busy
    );

endinterface

// File: rtl/ppm_edge_sync.sv
// Two-flop synchronizer for the asynchronous PPM line plus a rising-edge detect.
module ppm_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    // [0] and [1] form the synchronizer; [2] is the previous synchronized level.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ppm_symbol_decoder.sv
// PPM front end: finds the two-pulse SOF, demodulates 1-of-4 symbols into bytes and flags EOF/errors.
module ppm_symbol_decoder
    import ppm_pkg::*;
#(
    parameter int SLOT_CYCLES = 8,
    parameter int TOL         = 2
) (
    input logic           clk,
    input logic           rst_n,
    ppm_symbol_decoder_if.slave bus
);

    localparam int CNT_W   = $clog2(3 * SLOT_CYCLES + TOL + 2);
    localparam int GAP_NOM = SOF_GAP_SLOTS * SLOT_CYCLES;

    localparam logic [CNT_W-1:0] GAP_MIN   = CNT_W'(GAP_NOM - TOL);
    localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(GAP_NOM + TOL);
    localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_NOM + TOL + 1);
    localparam logic [CNT_W-1:0] CYC_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [1:0]       SLOT_LAST = 2'(SLOTS_PER_SYMBOL - 1);
    localparam logic [1:0]       IDX_LAST  = 2'(SYMBOLS_PER_BYTE - 1);

    logic rise;

    ppm_edge_sync u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (bus.ppm_in),
        .rise  (rise)
    );

    ppm_state_e       state_q, state_d;
    logic [CNT_W-1:0] gap_q, gap_d, gap_inc;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic [1:0]       slot_q, slot_d;
    logic [1:0]       idx_q, idx_d;
    logic [1:0]       sym_q, sym_d, cur_sym;
    logic             seen_q, seen_d;
    logic [7:0]       byte_q, byte_d, byte_fill;
    logic [7:0]       dout_q, dout_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             onebyte_q, onebyte_d;
    logic             err_q, err_d;
    logic             busy_q;
    logic             win_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gap_q     <= '0;
            cyc_q     <= '0;
            slot_q    <= '0;
            idx_q     <= '0;
            sym_q     <= '0;
            seen_q    <= 1'b0;
            byte_q    <= '0;
            dout_q    <= '0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            onebyte_q <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            cyc_q     <= cyc_d;
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            sym_q     <= sym_d;
            seen_q    <= seen_d;
            byte_q    <= byte_d;
            dout_q    <= dout_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            onebyte_q <= onebyte_d;
            err_q     <= err_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        cyc_d     = cyc_q;
        slot_d    = slot_q;
        idx_d     = idx_q;
        sym_d     = sym_q;
        seen_d    = seen_q;
        byte_d    = byte_q;
        dout_d    = dout_q;
        sof_d     = 1'b0;
        eof_d     = 1'b0;
        onebyte_d = 1'b0;
        err_d     = 1'b0;

        // gap_inc is the number of cycles elapsed since the pending first SOF pulse.
        gap_inc  = gap_q + CNT_W'(1);
        win_last = (slot_q == SLOT_LAST) && (cyc_q == CYC_LAST);
        cur_sym  = rise ? slot_q : sym_q;
        byte_fill = byte_q;
        byte_fill[{idx_q, 1'b0} +: 2] = cur_sym;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    gap_d   = '0;
                    state_d = SOF_GAP;
                end
            end

            SOF_GAP: begin
                gap_d = gap_inc;
                if (rise) begin
                    if (gap_inc >= GAP_MIN && gap_inc <= GAP_MAX) begin
                        state_d = DATA;
                        sof_d   = 1'b1;
                        cyc_d   = '0;
                        slot_d  = '0;
                        idx_d   = '0;
                        seen_d  = 1'b0;
                        byte_d  = '0;
                    end else begin
                        gap_d = '0;
                    end
                end else if (gap_inc >= GAP_LIMIT) begin
                    state_d = IDLE;
                end
            end

            DATA: begin
                if (rise && seen_q) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (rise) begin
                        seen_d = 1'b1;
                        sym_d  = slot_q;
                    end
                    // An edge on the final cycle still counts toward this window.
                    if (win_last) begin
                        cyc_d  = '0;
                        slot_d = '0;
                        seen_d = 1'b0;
                        if (seen_q || rise) begin
                            byte_d = byte_fill;
                            if (idx_q == IDX_LAST) begin
                                dout_d    = byte_fill;
                                onebyte_d = 1'b1;
                                idx_d     = '0;
                            end else begin
                                idx_d = idx_q + 2'd1;
                            end
                        end else if (idx_q == 2'd0) begin
                            eof_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (cyc_q == CYC_LAST) begin
                        cyc_d  = '0;
                        slot_d = slot_q + 2'd1;
                    end else begin
                        cyc_d = cyc_q + CNT_W'(1);
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign bus.dout_data   = dout_q;
    assign bus.onebyte_out = onebyte_q;
    assign bus.sof_rcv_out = sof_q;
    assign bus.eof_rcv_out = eof_q;
    assign bus.frame_err   = err_q;
    assign bus.busy        = busy_q;

endmodule
